// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Constants, the capture-buffer state encoding and a
//                bit-reversal helper. These are shared by the filter capture
//                buffer and the FFT stage.
//                Contents:
//                  DATA_W, ADDR_W, DEPTH, N_SAMPLES  frame geometry
//                  cap_state_t                       CAPTURE/PAD/FULL/READ
//                  bitrev()                          ADDR_W-bit reversal
//  Revision    : 1.0  initial release
// ============================================================================
package fft_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 10;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int N_SAMPLES = 1000;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    PAD     = 2'd1,
    FULL    = 2'd2,
    READ    = 2'd3
  } cap_state_t;

  // Mirror the ADDR_W-bit address: bit 0 <-> bit ADDR_W-1, and so on.
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      r[b] = v[ADDR_W-1-b];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// ============================================================================
//  Module      : capture_ram
//  Description : Simple dual-port RAM, DATA_W x 2**ADDR_W. It has one write
//                port and one synchronous read port with 1-cycle read latency.
//                It is written in a form that maps onto block RAM.
//                Ports:
//                  clk      clock
//                  wr_en    write strobe
//                  wr_addr  write address
//                  wr_data  write word
//                  rd_en    read strobe (rd_data updates one edge later)
//                  rd_addr  read address
//                  rd_data  registered read word (held while rd_en=0)
//  Revision    : 1.0  initial release
// ============================================================================
module capture_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int c_depth = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:c_depth-1];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // The read register has no reset, so the array can map to a block RAM
  // output register.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/filter_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : filter_capture_buffer
//  Description : Captures one frame of N_SAMPLES filter outputs and zero-pads
//                it to 2**ADDR_W words. It then streams the frame to the FFT
//                stage in natural or bit-reversed order over valid/ready.
//                Words are stored and returned bit-exact.
//                Ports:
//                  clk, rst          clock, synchronous active-high reset
//                  in_valid/in_data  sample strobe and word from the filter
//                  in_ready          high while capturing
//                  rearm             discard frame, restart capture (FULL)
//                  rd_start          start readout (FULL)
//                  rd_bitrev         readout order latched with rd_start
//                  rd_valid/rd_data  readout stream
//                  rd_index          natural sequence number of rd_data
//                  rd_last           marks index 2**ADDR_W-1
//                  rd_ready          consumer accepts the word
//                  capture_done      frame complete (FULL and READ)
//                  overrun           sticky: sample offered while not ready
//  Revision    : 1.0  initial release
// ============================================================================
module filter_capture_buffer #(
  parameter int DATA_W    = fft_pkg::DATA_W,
  parameter int ADDR_W    = fft_pkg::ADDR_W,
  parameter int N_SAMPLES = fft_pkg::N_SAMPLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              rearm,
  input  logic              rd_start,
  input  logic              rd_bitrev,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_index,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic              capture_done,
  output logic              overrun
);

  import fft_pkg::*;

  localparam int                c_depth       = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_last_addr   = '1;
  localparam logic [ADDR_W-1:0] c_last_sample = ADDR_W'(N_SAMPLES - 1);
  localparam logic              c_no_pad      = (N_SAMPLES == c_depth);

  // Control and capture state
  cap_state_t        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_in_ready;
  logic              r_capture_done;
  logic              r_overrun;

  // Readout issue side
  logic              r_bitrev;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic              r_issue_done;
  logic              r_pend;        // RAM word for r_pend_idx shows on w_ram_q
  logic [ADDR_W-1:0] r_pend_idx;

  // Output register and one-entry skid register
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_idx;
  logic              r_out_last;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [ADDR_W-1:0] r_skid_idx;

  // Combinational
  logic              w_wr_en;
  logic [DATA_W-1:0] w_wr_data;
  logic [ADDR_W-1:0] w_rev_cnt;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_ram_q;
  logic              w_pop;
  logic [1:0]        w_held;
  logic              w_room;
  logic              w_issue;

  // ---------------------------------------------------------------------------
  // Write port: accepted samples during capture, zero words during padding.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = in_data;
    if (r_state == CAPTURE) begin
      w_wr_en = in_valid && r_in_ready;
    end else if (r_state == PAD) begin
      w_wr_en   = 1'b1;
      w_wr_data = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read address. The bit reversal is done locally so it follows this
  // instance's ADDR_W, not the package default width.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rev_cnt = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      w_rev_cnt[b] = r_rd_cnt[ADDR_W-1-b];
    end
    w_rd_addr = r_bitrev ? w_rev_cnt : r_rd_cnt;
  end

  // A read may be issued only if its word has a free slot when it arrives,
  // even if the consumer stalls from now on. Words held after this edge are
  // out + skid + pending - pop. These plus the new word must fit in the two
  // slots.
  always_comb begin
    w_pop   = r_out_valid && rd_ready;
    w_held  = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_pend};
    w_room  = (w_held <= (2'd1 + {1'b0, w_pop}));
    w_issue = (r_state == READ) && !r_issue_done && w_room;
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_wr_ptr),
    .wr_data (w_wr_data),
    .rd_en   (w_issue),
    .rd_addr (w_rd_addr),
    .rd_data (w_ram_q)
  );

  // ---------------------------------------------------------------------------
  // Control FSM, read pipeline and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= CAPTURE;
      r_wr_ptr       <= '0;
      r_in_ready     <= 1'b1;
      r_capture_done <= 1'b0;
      r_overrun      <= 1'b0;
      r_bitrev       <= 1'b0;
      r_rd_cnt       <= '0;
      r_issue_done   <= 1'b0;
      r_pend         <= 1'b0;
      r_pend_idx     <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_idx      <= '0;
      r_out_last     <= 1'b0;
      r_skid_valid   <= 1'b0;
      r_skid_data    <= '0;
      r_skid_idx     <= '0;
    end else begin
      // An offered sample is dropped whenever capture is closed.
      if (in_valid && !r_in_ready) begin
        r_overrun <= 1'b1;
      end

      // Issue stage
      r_pend <= w_issue;
      if (w_issue) begin
        r_pend_idx <= r_rd_cnt;
        if (r_rd_cnt == c_last_addr) begin
          r_issue_done <= 1'b1;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end

      // Output / skid stage. The skid entry is always older than the
      // pending RAM word, so it refills the output register first.
      if (w_pop || !r_out_valid) begin
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_skid_data;
          r_out_idx    <= r_skid_idx;
          r_out_last   <= (r_skid_idx == c_last_addr);
          r_skid_valid <= r_pend;
          r_skid_data  <= w_ram_q;
          r_skid_idx   <= r_pend_idx;
        end else if (r_pend) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_ram_q;
          r_out_idx   <= r_pend_idx;
          r_out_last  <= (r_pend_idx == c_last_addr);
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (r_pend) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_ram_q;
        r_skid_idx   <= r_pend_idx;
      end

      case (r_state)
        CAPTURE: begin
          if (w_wr_en) begin
            if (r_wr_ptr == c_last_sample) begin
              r_in_ready <= 1'b0;
              if (c_no_pad) begin
                r_state        <= FULL;
                r_capture_done <= 1'b1;
              end else begin
                r_state  <= PAD;
                r_wr_ptr <= r_wr_ptr + 1'b1;
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end

        PAD: begin
          if (r_wr_ptr == c_last_addr) begin
            r_state        <= FULL;
            r_capture_done <= 1'b1;
          end else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end
        end

        FULL: begin
          if (rearm) begin
            r_state        <= CAPTURE;
            r_wr_ptr       <= '0;
            r_in_ready     <= 1'b1;
            r_capture_done <= 1'b0;
            r_overrun      <= 1'b0;
          end else if (rd_start) begin
            r_state      <= READ;
            r_bitrev     <= rd_bitrev;
            r_rd_cnt     <= '0;
            r_issue_done <= 1'b0;
          end
        end

        READ: begin
          // The last word is the final one in flight, so the pipeline is
          // empty once it is accepted.
          if (w_pop && r_out_last) begin
            r_state <= FULL;
          end
        end

        default: r_state <= CAPTURE;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign capture_done = r_capture_done;
  assign overrun      = r_overrun;
  assign rd_valid     = r_out_valid;
  assign rd_data      = r_out_data;
  assign rd_index     = r_out_idx;
  assign rd_last      = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_filter_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_filter_capture_buffer
//  Description : Self-checking bench for filter_capture_buffer. A frame image
//                kept as a plain array predicts every streamed word. Natural
//                and bit-reversed orders are derived arithmetically.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_filter_capture_buffer;

  localparam int N     = 1000;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        rearm;
  logic        rd_start;
  logic        rd_bitrev;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [9:0]  rd_index;
  logic        rd_last;
  logic        rd_ready;
  logic        capture_done;
  logic        overrun;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] frame_img [DEPTH];   // expected buffer contents
  logic [31:0] rx        [DEPTH];   // words received by index, last read

  always #5 clk = ~clk;

  filter_capture_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .rearm        (rearm),
    .rd_start     (rd_start),
    .rd_bitrev    (rd_bitrev),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_index     (rd_index),
    .rd_last      (rd_last),
    .rd_ready     (rd_ready),
    .capture_done (capture_done),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reverse a 10-bit number by peeling off low bits arithmetically.
  function automatic int rev10(input int v);
    int r = 0;
    int x = v;
    for (int b = 0; b < 10; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_word(input int i, input bit rev);
    return frame_img[rev ? rev10(i) : i];
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"},     in_ready,     1);
    check({pfx, "_capture_done"}, capture_done, 0);
    check({pfx, "_overrun"},      overrun,      0);
    check({pfx, "_rd_valid"},     rd_valid,     0);
    check({pfx, "_rd_data"},      rd_data,      0);
    check({pfx, "_rd_index"},     rd_index,     0);
    check({pfx, "_rd_last"},      rd_last,      0);
  endtask

  // Feed nsamp samples. rnd=0: data k, one sample every 3rd cycle.
  // rnd=1: random data with 0..3 idle cycles between samples.
  task automatic feed_frame(input int nsamp, input bit rnd);
    int n;
    int idle;
    for (int k = 0; k < nsamp; k++) begin
      in_data      = rnd ? $urandom : k;
      in_valid     = 1'b1;
      frame_img[k] = in_data;
      @(negedge clk);
      in_valid = 1'b0;
      idle = rnd ? int'($urandom_range(0, 3)) : 2;
      if (k != nsamp - 1) repeat (idle) @(negedge clk);
    end
    if (nsamp == N) begin
      for (int a = N; a < DEPTH; a++) frame_img[a] = '0;
      check("in_ready_low_after_last_sample", in_ready, 0);
      n = 0;
      while (!capture_done && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("pad_cycles_to_capture_done", n, DEPTH - N);
    end
  endtask

  // Read one frame. poke=1 pulses rd_start and rearm mid-stream; both must
  // be ignored during readout.
  task automatic read_frame(input bit rev, input bit rnd_ready, input bit poke);
    int          n;
    int          i;
    bit          stall;
    logic [31:0] pd;
    logic [9:0]  pi;
    logic        pl;
    logic [31:0] exp;
    rd_bitrev = rev;
    rd_start  = 1'b1;
    rd_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    rd_start  = 1'b0;
    rd_bitrev = ~rev;
    n = 1;
    while (!rd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    // Start is sampled by the edge before the first negedge here, and valid
    // rises two edges later, so it becomes visible at the third negedge.
    check("first_valid_latency", n, 3);
    i = 0; n = 0; stall = 0; pd = '0; pi = '0; pl = 1'b0;
    while (i < DEPTH && n < 8000) begin
      if (stall) begin
        check("stall_valid_held", rd_valid, 1);
        check("stall_data_stable", rd_data, pd);
        check("stall_index_stable", rd_index, pi);
        check("stall_last_stable", rd_last, pl);
      end
      rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && i == 100) begin
        rd_start = 1'b1;
        rearm    = 1'b1;
      end
      if (rd_valid && rd_ready) begin
        exp = model_word(i, rev);
        check("rd_index", rd_index, i);
        check("rd_data", rd_data, exp);
        check("rd_last", rd_last, (i == DEPTH - 1));
        rx[i] = rd_data;
        i++;
        stall = 0;
      end else begin
        stall = rd_valid;
        pd = rd_data; pi = rd_index; pl = rd_last;
      end
      @(negedge clk);
      rd_start = 1'b0;
      rearm    = 1'b0;
      n++;
    end
    check("words_received", i, DEPTH);
    check("rd_valid_low_after_last", rd_valid, 0);
    if (!rnd_ready) check("stream_cycles_full_rate", n, DEPTH);
    check("capture_done_after_read", capture_done, 1);
    check("in_ready_low_after_read", in_ready, 0);
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("no_restart_after_read", rd_valid, 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; rearm = 1'b0;
    rd_start = 1'b0; rd_bitrev = 1'b0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    // Frame A: data k, one sample every 3rd cycle
    feed_frame(N, 1'b0);
    check("capture_done_frame_a", capture_done, 1);
    read_frame(1'b0, 1'b0, 1'b0);
    read_frame(1'b1, 1'b0, 1'b0);
    check("bitrev_idx0", rx[0], 0);
    check("bitrev_idx1", rx[1], 512);
    check("bitrev_idx2", rx[2], 256);
    check("bitrev_idx3", rx[3], 768);
    check("bitrev_idx1023_pad", rx[1023], 0);

    // Backpressure, plus ignored rd_start/rearm during readout
    read_frame(1'b0, 1'b1, 1'b1);
    read_frame(1'b1, 1'b1, 1'b0);

    // Overrun in FULL: the word is dropped and the frame is untouched
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    in_valid = 1'b0;
    check("overrun_set", overrun, 1);
    read_frame(1'b0, 1'b0, 1'b0);
    check("overrun_sticky", overrun, 1);

    // rearm together with rd_start: rearm wins
    rearm = 1'b1; rd_start = 1'b1;
    @(negedge clk);
    rearm = 1'b0; rd_start = 1'b0;
    check("rearm_in_ready", in_ready, 1);
    check("rearm_capture_done", capture_done, 0);
    check("rearm_overrun_cleared", overrun, 0);
    repeat (3) @(negedge clk);
    check("rearm_no_readout", rd_valid, 0);

    // Frame B after rearm: capture restarts at address 0
    feed_frame(N, 1'b1);
    read_frame(1'b1, 1'b1, 1'b1);
    read_frame(1'b1, 1'b0, 1'b0);

    // Reset in the middle of frame C
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    feed_frame(500, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midcap");

    // Frame D after reset must land at address 0
    feed_frame(N, 1'b1);
    read_frame(1'b1, 1'b1, 1'b0);
    read_frame(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/filter_capture_buffer.md
Name: filter_capture_buffer

Overview:
Downstream stage of the FIR filter. Captures the stream of float32 filtered samples y[n] (N_SAMPLES per frame) into a 2**ADDR_W-deep buffer and zero-pads the buffer to a power of two. It then serves the frame to the FFT stage over a valid/ready stream, in natural or bit-reversed order. The buffer is data-agnostic: words are stored and returned bit-exact.

Parameters:
DATA_W, 32, sample word width (IEEE-754 single)
ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W = 1024
N_SAMPLES, 1000, filter outputs per frame; legal range 1..DEPTH

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  filter output word valid (one-cycle strobe per y update)
in_data  in  DATA_W  filter output y[n]
in_ready  out  1  buffer accepting samples (high only in CAPTURE)
rearm  in  1  pulse: discard frame, restart capture (honoured only in FULL)
rd_start  in  1  pulse: begin frame readout (honoured only in FULL)
rd_bitrev  in  1  readout order, sampled with rd_start: 0 natural, 1 bit-reversed
rd_valid  out  1  readout word valid
rd_data  out  DATA_W  readout word
rd_index  out  ADDR_W  sequence index of the current word, 0..DEPTH-1
rd_last  out  1  high with index DEPTH-1
rd_ready  in  1  consumer accepts the word
capture_done  out  1  frame complete and padded (high in FULL and READ)
overrun  out  1  sticky: in_valid seen while in_ready=0

Behaviour:
- Reset values: state CAPTURE, wr_ptr=0, in_ready=1, capture_done=0, overrun=0, rd_valid=0, rd_data=0, rd_index=0, rd_last=0. Reset takes effect mid-frame in any state. RAM contents are not cleared.
- States: CAPTURE, PAD, FULL, READ.
- CAPTURE:
  - A word is written when in_valid && in_ready, at address wr_ptr; wr_ptr then increments.
  - The write at wr_ptr=N_SAMPLES-1 moves the block to PAD, or to FULL if N_SAMPLES==DEPTH. in_ready is low from the next cycle.
- PAD:
  - Writes 32'h0000_0000 to addresses N_SAMPLES..DEPTH-1, one per cycle: DEPTH-N_SAMPLES cycles, 24 at the defaults.
  - After the write to DEPTH-1, the block moves to FULL.
- FULL:
  - capture_done=1; the block waits.
  - rearm: to CAPTURE, wr_ptr=0, overrun cleared.
  - rd_start: latch rd_bitrev, rd_cnt=0, to READ.
  - rearm and rd_start in the same cycle: rearm wins.
- READ:
  - rd_cnt steps 0..DEPTH-1. RAM read address = rd_cnt, or bitrev_ADDR_W(rd_cnt) when the latched rd_bitrev=1.
  - The RAM is synchronous-read with 1-cycle latency. A one-entry skid register gives full throughput: 1 word per cycle while rd_ready=1.
  - The first rd_valid is asserted on the 2nd rising edge after the edge that samples rd_start.
  - Stream rules: while rd_valid && !rd_ready, rd_data, rd_index and rd_last hold stable. No word is lost or duplicated under any rd_ready pattern.
  - rd_index is always the natural sequence number (rd_cnt of that word), not the RAM address.
  - The handshake of the rd_last word returns the block to FULL with the frame intact, so re-reading is allowed. rd_valid is low the following cycle unless new data is present.
  - rd_start and rearm are ignored during READ.
- Overrun:
  - in_valid while in_ready=0 (PAD, FULL or READ) drops the word and sets overrun.
  - overrun stays set until rst or an accepted rearm.
- Pointers are ADDR_W bits. wr_ptr never passes DEPTH-1; no wrap occurs within a frame.
- No arithmetic is performed on the data.

Decomposition:
- Shared package fft_pkg:
  - constants DATA_W, ADDR_W, DEPTH, N_SAMPLES
  - capture state encoding (CAPTURE, PAD, FULL, READ)
  - function bitrev(ADDR_W-bit value), reused by the FFT stage
- Sub-module capture_ram: simple dual-port RAM with 1 write port, 1 synchronous read port and 1-cycle read latency, DATA_W x DEPTH. Infers block RAM.

Test Plan:
- Capture then natural readout: feed in_data=k for k=0..999 with in_valid every 3rd cycle, then rd_start with rd_bitrev=0 and rd_ready=1.
  - capture_done rises exactly 24 cycles after the sample-999 write.
  - Read returns rd_index=i, rd_data=i for i<1000 and 0 for 1000..1023; rd_last only at i=1023.
  - 1024 consecutive valid cycles; first rd_valid 2 edges after rd_start.
- Bit-reversed readout of the same frame: rd_bitrev=1.
  - Index 0 -> data 0; 1 -> 512; 2 -> 256; 3 -> 768; 1023 -> 0 (address 1023 is pad).
- Backpressure: random rd_ready at 50% duty.
  - All 1024 words delivered in order, none dropped or duplicated.
  - Outputs stable whenever rd_valid && !rd_ready.
- Overrun: after the frame fills, pulse in_valid with in_data=32'hDEADBEEF.
  - overrun=1 and the buffer contents are unchanged.
  - rearm clears overrun; in_ready=1 the next cycle; wr_ptr restarts at 0.
- Reset mid-capture: rst after 500 samples.
  - All outputs return to their reset values; the next frame captures from address 0.
- Control conflict and re-read:
  - rearm+rd_start together in FULL -> CAPTURE.
  - rd_start during READ is ignored.
  - A second rd_start after rd_last re-reads an identical frame.
